// File: rtl/burst_ram_arbiter_if.sv
// Client/BurstRAM bundle for burst_ram_arbiter: per-client request/command lanes plus the shared RAM port.
// slave = arbiter side, master = clients + RAM model side.
interface burst_ram_arbiter_if #(
    parameter int CLIENT_COUNT            = 2,
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64
);
    localparam int MW = RAM_BURST_DATA_BITWIDTH / 8;

    logic [CLIENT_COUNT-1:0]                         req;
    logic [CLIENT_COUNT-1:0]                         gnt;
    logic [CLIENT_COUNT-1:0]                         c_cmd;
    logic [CLIENT_COUNT-1:0]                         c_cmd_en;
    logic [CLIENT_COUNT*RAM_DEPTH_BITWIDTH-1:0]      c_addr;
    logic [CLIENT_COUNT*RAM_BURST_DATA_BITWIDTH-1:0] c_wr_data;
    logic [CLIENT_COUNT*MW-1:0]                      c_data_mask;
    logic [CLIENT_COUNT-1:0]                         c_rd_data_valid;
    logic [CLIENT_COUNT-1:0]                         c_busy;

    logic                               br_cmd;
    logic                               br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] br_wr_data;
    logic [MW-1:0]                      br_data_mask;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data;
    logic                               br_rd_data_valid;
    logic                               br_busy;

    // Read data bypasses the arbiter, so it is absent from the slave view.
    modport slave (
        input  req, c_cmd, c_cmd_en, c_addr, c_wr_data, c_data_mask,
        input  br_rd_data_valid, br_busy,
        output gnt, c_rd_data_valid, c_busy,
        output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
    );

    modport master (
        output req, c_cmd, c_cmd_en, c_addr, c_wr_data, c_data_mask,
        output br_rd_data, br_rd_data_valid, br_busy,
        input  gnt, c_rd_data_valid, c_busy,
        input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// N-client round-robin owner arbiter for one BurstRAM port; ownership held until req drops and reads drain.
// Define BURST_RAM_ARBITER_FIXED_PRIORITY_EN to pick the lowest requesting index instead of round-robin.
module burst_ram_arbiter #(
    parameter int CLIENT_COUNT            = 2,
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic               clk,
    input  logic               rst,
    burst_ram_arbiter_if.slave bus
);
    localparam int MW = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int BW = $clog2(2 * RAM_BURST_DATA_COUNT + 1);
    localparam int LW = (CLIENT_COUNT > 1) ? $clog2(CLIENT_COUNT) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                  state_q, state_d;
    logic [CLIENT_COUNT-1:0] gnt_q, gnt_d;
    logic [BW-1:0]           beats_q, beats_d;
    logic                    pick_found;
    logic [LW-1:0]           pick_idx;
    logic                    rd_accept;
    logic                    owner_req;

`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        pick_found = |bus.req;
        pick_idx   = '0;
        for (int i = CLIENT_COUNT - 1; i >= 0; i--) begin
            if (bus.req[i]) pick_idx = LW'(i);
        end
    end
`else
    logic [LW-1:0] last_q, last_d;

    // Two passes: indices above last first, then wrap to 0..last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < CLIENT_COUNT; i++) begin
            if (!pick_found && bus.req[i] && (i > int'(last_q))) begin
                pick_found = 1'b1;
                pick_idx   = LW'(i);
            end
        end
        for (int i = 0; i < CLIENT_COUNT; i++) begin
            if (!pick_found && bus.req[i] && (i <= int'(last_q))) begin
                pick_found = 1'b1;
                pick_idx   = LW'(i);
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && pick_found) last_d = pick_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= LW'(CLIENT_COUNT - 1);
        else     last_q <= last_d;
    end
`endif

    always_comb begin
        bus.br_cmd       = 1'b0;
        bus.br_cmd_en    = 1'b0;
        bus.br_addr      = '0;
        bus.br_wr_data   = '0;
        bus.br_data_mask = '0;
        for (int i = 0; i < CLIENT_COUNT; i++) begin
            if (gnt_q[i]) begin
                bus.br_cmd       = bus.c_cmd[i];
                bus.br_cmd_en    = bus.c_cmd_en[i];
                bus.br_addr      = bus.c_addr[i*RAM_DEPTH_BITWIDTH +: RAM_DEPTH_BITWIDTH];
                bus.br_wr_data   = bus.c_wr_data[i*RAM_BURST_DATA_BITWIDTH +: RAM_BURST_DATA_BITWIDTH];
                bus.br_data_mask = bus.c_data_mask[i*MW +: MW];
            end
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.c_rd_data_valid = gnt_q & {CLIENT_COUNT{bus.br_rd_data_valid}};
    assign bus.c_busy          = ~gnt_q | {CLIENT_COUNT{bus.br_busy}};

    assign rd_accept = bus.br_cmd_en & ~bus.br_cmd & ~bus.br_busy;
    assign owner_req = |(bus.req & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        beats_d = beats_q;
        if (rd_accept) beats_d = beats_d + BW'(RAM_BURST_DATA_COUNT);
        // A stray valid with nothing outstanding must not wrap the counter.
        if (bus.br_rd_data_valid && beats_q != '0) beats_d = beats_d - BW'(1);
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    gnt_d   = CLIENT_COUNT'(1) << pick_idx;
                end
            end
            OWNED: begin
                // A read accepted this cycle still counts as outstanding.
                if (!owner_req && beats_q == '0 && !rd_accept && !bus.br_busy) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            beats_q <= beats_d;
        end
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with three clients: reset, read hold, strobe isolation,
// busy hold, reset mid-burst, grant order, and picking policy (follows the build macro).
module tb_burst_ram_arbiter;
    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 64;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    burst_ram_arbiter_if #(.CLIENT_COUNT(N), .RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW)) bus();

    burst_ram_arbiter #(
        .CLIENT_COUNT(N), .RAM_DEPTH_BITWIDTH(AW),
        .RAM_BURST_DATA_BITWIDTH(DW), .RAM_BURST_DATA_COUNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] wd [N];
    int            order [6];
    logic [N-1:0]  oh;

    initial begin
        bus.req = '0; bus.c_cmd = '0; bus.c_cmd_en = '0;
        bus.c_addr = '0; bus.c_wr_data = '0; bus.c_data_mask = '0;
        bus.br_rd_data = '0; bus.br_rd_data_valid = 1'b0; bus.br_busy = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_gnt", 64'(bus.gnt), 64'h0);
        check("rst_cmd_en", 64'(bus.br_cmd_en), 64'h0);
        check("rst_busy", 64'(bus.c_busy), 64'h7);
        check("rst_rdv", 64'(bus.c_rd_data_valid), 64'h0);
        check("rst_addr", 64'(bus.br_addr), 64'h0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_gnt", 64'(bus.gnt), 64'h0);

        // Read by client 0, req dropped before beats arrive.
        bus.req = 3'b001;
        cyc();
        check("rd_gnt", 64'(bus.gnt), 64'h1);
        bus.c_cmd_en = 3'b001; bus.c_cmd = 3'b000; bus.c_addr[0 +: AW] = 4'd5;
        bus.c_data_mask[0 +: 8] = 8'hF0;
        #1;
        check("rd_cmd_en", 64'(bus.br_cmd_en), 64'h1);
        check("rd_addr", 64'(bus.br_addr), 64'h5);
        check("rd_mask", 64'(bus.br_data_mask), 64'hF0);
        check("rd_busy", 64'(bus.c_busy), 64'h6);
        cyc();
        bus.c_cmd_en = '0; bus.req = '0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("rd_hold_gnt", 64'(bus.gnt), 64'h1);
        end
        bus.br_rd_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rd_beat_rdv", 64'(bus.c_rd_data_valid), 64'h1);
            check("rd_beat_gnt", 64'(bus.gnt), 64'h1);
            cyc();
        end
        bus.br_rd_data_valid = 1'b0;
        #1;
        check("rd_last_gnt", 64'(bus.gnt), 64'h1);
        check("rd_last_rdv", 64'(bus.c_rd_data_valid), 64'h0);
        cyc();
        check("rd_release", 64'(bus.gnt), 64'h0);

        // Non-granted strobe never reaches the RAM.
        bus.req = 3'b001;
        cyc();
        bus.c_addr[0 +: AW] = 4'd3; bus.c_wr_data[0 +: DW] = 64'hA0A0;
        bus.c_addr[AW +: AW] = 4'd9; bus.c_cmd_en = 3'b010; bus.c_cmd = 3'b010;
        #1;
        check("iso_cmd_en", 64'(bus.br_cmd_en), 64'h0);
        check("iso_cmd", 64'(bus.br_cmd), 64'h0);
        check("iso_addr", 64'(bus.br_addr), 64'h3);
        check("iso_wdata", 64'(bus.br_wr_data), 64'hA0A0);
        check("iso_busy1", 64'(bus.c_busy[1]), 64'h1);
        bus.c_cmd_en = '0; bus.c_cmd = '0; bus.req = '0;
        cyc();
        check("iso_release", 64'(bus.gnt), 64'h0);

        // br_busy holds ownership after req drops.
        bus.req = 3'b001;
        cyc();
        check("bsy_gnt", 64'(bus.gnt), 64'h1);
        bus.req = 3'b010; bus.br_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("bsy_hold", 64'(bus.gnt), 64'h1);
        end
        bus.br_busy = 1'b0;
        #1;
        check("bsy_cbusy", 64'(bus.c_busy), 64'h6);
        cyc();
        check("bsy_idle", 64'(bus.gnt), 64'h0);
        cyc();
        check("bsy_next", 64'(bus.gnt), 64'h2);
        bus.req = '0;
        cyc();
        check("bsy_release", 64'(bus.gnt), 64'h0);

        // Reset in the middle of a read burst owned by client 1.
        bus.req = 3'b010;
        cyc();
        check("mr_gnt", 64'(bus.gnt), 64'h2);
        bus.c_cmd_en = 3'b010; bus.c_addr[AW +: AW] = 4'd7;
        #1;
        check("mr_addr", 64'(bus.br_addr), 64'h7);
        cyc();
        bus.c_cmd_en = '0; bus.br_rd_data_valid = 1'b1;
        cyc();
        rst = 1'b1;
        #1;
        check("mr_gnt0", 64'(bus.gnt), 64'h0);
        check("mr_cmd_en", 64'(bus.br_cmd_en), 64'h0);
        check("mr_busy", 64'(bus.c_busy), 64'h7);
        check("mr_rdv", 64'(bus.c_rd_data_valid), 64'h0);
        bus.req = '0;
        cyc();
        check("mr_rdv_hold", 64'(bus.c_rd_data_valid), 64'h0);
        bus.br_rd_data_valid = 1'b0; rst = 1'b0;
        cyc(); cyc();
        check("mr_after", 64'(bus.gnt), 64'h0);

        // Grant order with all requesting; each owner writes then bounces req.
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
        order = '{0, 0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 0, 1, 2};
`endif
        for (int i = 0; i < N; i++) begin
            wd[i] = 64'h1111_0000_0000_0000 * 64'(i + 1) + 64'(i);
            bus.c_wr_data[i*DW +: DW] = wd[i];
        end
        bus.req = 3'b111;
        cyc();
        for (int g = 0; g < 6; g++) begin
            oh = 3'b001 << order[g];
            check("rr_gnt", 64'(bus.gnt), 64'(oh));
            bus.c_cmd_en = oh; bus.c_cmd = oh;
            #1;
            check("rr_wcmd", 64'(bus.br_cmd), 64'h1);
            check("rr_wdata", 64'(bus.br_wr_data), 64'(wd[order[g]]));
            cyc();
            bus.c_cmd_en = '0; bus.c_cmd = '0; bus.req = 3'b111 & ~oh;
            cyc();
            check("rr_idle", 64'(bus.gnt), 64'h0);
            bus.req = 3'b111;
            cyc();
        end

        // Picking policy with several waiters.
        bus.req = '0;
        cyc();
        check("pp_idle0", 64'(bus.gnt), 64'h0);
        bus.req = 3'b100;
        cyc();
        check("pp_g2", 64'(bus.gnt), 64'h4);
        bus.req = 3'b110;
        cyc();
        bus.req = 3'b111;
        cyc();
        check("pp_g2_hold", 64'(bus.gnt), 64'h4);
        bus.req = 3'b011;
        cyc();
        check("pp_idle1", 64'(bus.gnt), 64'h0);
        cyc();
        check("pp_g0", 64'(bus.gnt), 64'h1);
        bus.req = 3'b010;
        cyc();
        check("pp_idle2", 64'(bus.gnt), 64'h0);
        cyc();
        check("pp_g1", 64'(bus.gnt), 64'h2);
        bus.req = 3'b101;
        cyc();
        check("pp_idle3", 64'(bus.gnt), 64'h0);
        cyc();
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
        check("pp_pick", 64'(bus.gnt), 64'h1);
`else
        check("pp_pick", 64'(bus.gnt), 64'h4);
`endif
        bus.req = '0;
        cyc(); cyc();
        check("pp_end", 64'(bus.gnt), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- N-client arbiter that shares one BurstRAM command/data port among instruction, data and future clients (DMA, video), replacing the fixed two-way icache/dcache toggle.
- Grants ownership round-robin. Ownership is held until the client drops its request and no read burst is outstanding.
- Muxes the command, address, write data and mask of the granted client onto the RAM. Steers read-valid and busy back to the granted client only.

Parameters:
- CLIENT_COUNT, 2, number of clients (>=2).
- RAM_DEPTH_BITWIDTH, 4, BurstRAM address width.
- RAM_BURST_DATA_BITWIDTH, 64, width of one burst beat.
- RAM_BURST_DATA_COUNT, 4, beats returned per read command.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  CLIENT_COUNT  per-client ownership request, level
- gnt  out  CLIENT_COUNT  one-hot grant, registered
- c_cmd  in  CLIENT_COUNT  per-client command (1 = write, 0 = read)
- c_cmd_en  in  CLIENT_COUNT  per-client command strobe
- c_addr  in  CLIENT_COUNT*RAM_DEPTH_BITWIDTH  flattened addresses; client i uses slice i
- c_wr_data  in  CLIENT_COUNT*RAM_BURST_DATA_BITWIDTH  flattened write data
- c_data_mask  in  CLIENT_COUNT*RAM_BURST_DATA_BITWIDTH/8  flattened byte masks
- c_rd_data_valid  out  CLIENT_COUNT  br_rd_data_valid gated to the granted client
- c_busy  out  CLIENT_COUNT  br_busy for the granted client; 1 for all others
- br_cmd  out  1  to BurstRAM
- br_cmd_en  out  1  to BurstRAM
- br_addr  out  RAM_DEPTH_BITWIDTH  to BurstRAM
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  to BurstRAM
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  to BurstRAM
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  from BurstRAM; clients take it directly, it is not routed through this block
- br_rd_data_valid  in  1  from BurstRAM
- br_busy  in  1  from BurstRAM

Behaviour:
- Reset values:
  - state = IDLE, gnt = 0, last = CLIENT_COUNT-1, beats = 0.
  - br_cmd_en = 0, br_cmd = 0, br_addr/br_wr_data/br_data_mask = 0.
  - c_busy = all 1, c_rd_data_valid = 0.
- Reset mid-burst: grant is dropped immediately. Remaining read beats are not forwarded to any client.
- States:
  - IDLE -> OWNED: when any req bit is 1, pick the first requesting index scanning from last+1 with wrap. Set gnt one-hot and last = that index.
  - OWNED -> IDLE: when req[granted]=0 AND beats=0 AND br_busy=0, clear gnt.
- Grant latency: req high at edge k gives gnt high after edge k. At least one IDLE cycle separates consecutive owners.
- Mux is combinational from the registered gnt:
  - gnt=0: br_cmd_en = 0 and the data outputs are 0.
  - gnt!=0: the granted client's c_cmd, c_cmd_en, addr, wr_data and mask drive br_*.
- c_cmd_en from non-granted clients is ignored and never reaches the RAM.
- Beat counter:
  - On an accepted read (granted c_cmd_en=1, c_cmd=0, br_busy=0), beats += RAM_BURST_DATA_COUNT.
  - Each br_rd_data_valid decrements beats by 1.
  - Width is clog2(2*RAM_BURST_DATA_COUNT+1). Simultaneous load and decrement nets both effects.
- Client rules:
  - A client must not issue a command while c_busy=1.
  - Dropping req while a burst is pending defers release until beats reaches 0.
  - br_rd_data_valid with beats=0 is a protocol error: it is forwarded to the current owner only and beats stays 0 (no underflow).
- Fairness:
  - A client that holds req continuously and then releases will not be granted again before every other requester waiting at release time has been served.
  - A lone requester is re-granted after one IDLE cycle.
- Writes: no beat counting. Release waits only for br_busy=0.

Optional Feature:
- Macro: BURST_RAM_ARBITER_FIXED_PRIORITY_EN.
- Defined: the IDLE pick is the lowest requesting index, and last is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset asserted mid-read with client 1 granted and beats=3 -> gnt=0, br_cmd_en=0 and c_busy=11 in the same cycle. After rst falls with no req, gnt stays 0.
- CLIENT_COUNT=3; req=111 held for the whole run; each owner drops its req for one cycle after a write and then reasserts -> grant order 0,1,2,0,1,2 with exactly one IDLE cycle between grants.
- Client 0 issues a read at addr 5, then drops req before any beat arrives -> gnt stays 01 until the 4th br_rd_data_valid. c_rd_data_valid=01 for exactly 4 cycles. IDLE follows.
- Client 0 granted; client 1 pulses c_cmd_en=1 with addr 9 -> br_cmd_en stays 0, br_addr shows client 0's address, c_busy[1]=1.
- Client 0 granted with br_busy=1 held for 10 cycles and req dropped -> no release until br_busy=0. Client 1 is granted one cycle after IDLE is entered.
- Fixed-priority build, req=110 then 111 while client 2 owns -> after release, client 0 is granted before client 1.
